// File: rtl/npc_ifu_pkg.sv
// rtl/npc_ifu_pkg.sv - shared types and constants for the NPC instruction fetch stage
package npc_ifu_pkg;

  typedef enum logic [1:0] {
    S_AR      = 2'd0,
    S_R       = 2'd1,
    S_OUT     = 2'd2,
    S_WAIT_PC = 2'd3
  } ifu_state_t;

  localparam logic [31:0] INST_EBREAK      = 32'h0010_0073;
  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ifu_perf_cnt.sv
// rtl/ifu_perf_cnt.sv - fetch and memory-wait event counters (built only with IFU_PERF_CNT_EN)
module ifu_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_done,
  input  logic        wait_cycle,
  output logic [63:0] perf_fetch_cnt,
  output logic [63:0] perf_wait_cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= 64'd0;
      perf_wait_cnt  <= 64'd0;
    end else begin
      if (fetch_done) perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
      if (wait_cycle) perf_wait_cnt  <= perf_wait_cnt + 64'd1;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - NPC instruction fetch stage: AR/R read per instruction, {inst,pc} to decode
// Optional counters enabled by defining IFU_PERF_CNT_EN.
module ifu_fetch
  import npc_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          ADDR_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pc_update_valid,
  input  logic [ADDR_W-1:0]   pc_next,
  output logic [ADDR_W-1:0]   araddr,
  output logic                arvalid,
  input  logic                arready,
  input  logic [31:0]         rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready,
  output logic                ifu_valid,
  output logic [31+ADDR_W:0]  ifu_data,
  input  logic                idu_ready,
  output logic                fetch_fault
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [63:0]         perf_fetch_cnt,
  output logic [63:0]         perf_wait_cnt
`endif
);

  ifu_state_t        state, state_n;
  logic [ADDR_W-1:0] pc, pc_pending;
  logic              pending;
  logic              ar_fire, r_fire, out_fire, pc_take;
  logic [31:0]       inst;

  assign ar_fire  = arvalid & arready;
  assign r_fire   = rready & rvalid;
  assign out_fire = ifu_valid & idu_ready;
  assign pc_take  = (state == S_WAIT_PC) && (pending || pc_update_valid);
  assign inst     = (rresp != RESP_OKAY) ? INST_EBREAK : rdata;
  assign araddr   = pc;

  always_comb begin
    state_n = state;
    case (state)
      S_AR:      if (ar_fire)  state_n = S_R;
      S_R:       if (r_fire)   state_n = S_OUT;
      S_OUT:     if (out_fire) state_n = S_WAIT_PC;
      S_WAIT_PC: if (pc_take)  state_n = S_AR;
      default:   state_n = S_AR;
    endcase
  end

  // Handshake outputs are registered from the next state, so no ready input reaches them combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_AR;
      arvalid     <= 1'b0;
      rready      <= 1'b0;
      ifu_valid   <= 1'b0;
      ifu_data    <= '0;
      fetch_fault <= 1'b0;
      pc          <= RESET_PC[ADDR_W-1:0];
      pc_pending  <= '0;
      pending     <= 1'b0;
    end else begin
      state     <= state_n;
      arvalid   <= (state_n == S_AR);
      rready    <= (state_n == S_R);
      ifu_valid <= (state_n == S_OUT);
      if (r_fire) begin
        ifu_data <= {inst, pc};
        if (rresp != RESP_OKAY) fetch_fault <= 1'b1;
      end
      // A pulse arriving while waiting beats any older pending value.
      if (pc_take) begin
        pc      <= pc_update_valid ? pc_next : pc_pending;
        pending <= 1'b0;
      end else if (pc_update_valid) begin
        pc_pending <= pc_next;
        pending    <= 1'b1;
      end
    end
  end

`ifdef IFU_PERF_CNT_EN
  ifu_perf_cnt u_perf_cnt (
    .clk            (clk),
    .rst            (rst),
    .fetch_done     (out_fire),
    .wait_cycle     ((arvalid & ~arready) | (rready & ~rvalid)),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_wait_cnt  (perf_wait_cnt)
  );
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - directed and randomized self-checking bench for ifu_fetch
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_update_valid;
  logic [31:0] pc_next;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic        ifu_valid;
  logic [63:0] ifu_data;
  logic        idu_ready;
  logic        fetch_fault;
`ifdef IFU_PERF_CNT_EN
  logic [63:0] perf_fetch_cnt, perf_wait_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ifu_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .pc_update_valid (pc_update_valid),
    .pc_next         (pc_next),
    .araddr          (araddr),
    .arvalid         (arvalid),
    .arready         (arready),
    .rdata           (rdata),
    .rresp           (rresp),
    .rvalid          (rvalid),
    .rready          (rready),
    .ifu_valid       (ifu_valid),
    .ifu_data        (ifu_data),
    .idu_ready       (idu_ready),
    .fetch_fault     (fetch_fault)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_wait_cnt   (perf_wait_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
  endfunction

  task automatic idle_inputs();
    pc_update_valid = 1'b0; pc_next = '0; arready = 1'b0;
    rdata = '0; rresp = 2'b00; rvalid = 1'b0; idu_ready = 1'b0;
  endtask

  // Random-phase model state: what the next fetch address must be and what decode must receive.
  logic [31:0] latest_pc, cur_addr, exp_inst, r_addr;
  bit          have_new, busy, exp_fault, outstanding, r_err, stalled;
  int          r_delay, idle, n_fetch;
  logic        prev_arvalid, prev_ifu_valid, prev_idu_ready;
  logic [31:0] prev_araddr;
  logic [63:0] prev_ifu_data;
  longint unsigned exp_wait;

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    check("rst_arvalid", {63'd0, arvalid}, 64'd0);
    check("rst_rready", {63'd0, rready}, 64'd0);
    check("rst_ifu_valid", {63'd0, ifu_valid}, 64'd0);
    check("rst_ifu_data", ifu_data, 64'd0);
    check("rst_fault", {63'd0, fetch_fault}, 64'd0);

    // Zero-wait fetch from the reset PC.
    rst = 1'b0; arready = 1'b1;
    @(negedge clk);
    check("c1_arvalid", {63'd0, arvalid}, 64'd1);
    check("c1_araddr", {32'd0, araddr}, {32'd0, RST_PC});
    @(negedge clk);
    check("c2_rready", {63'd0, rready}, 64'd1);
    check("c2_ifu_valid", {63'd0, ifu_valid}, 64'd0);
    rvalid = 1'b1; rdata = 32'h0000_0513;
    @(negedge clk);
    rvalid = 1'b0; rdata = '0;
    check("c3_ifu_valid", {63'd0, ifu_valid}, 64'd1);
    check("c3_ifu_data", ifu_data, 64'h0000_0513_8000_0000);

    // Decode back-pressure holds the output stable.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", {63'd0, ifu_valid}, 64'd1);
      check("hold_data", ifu_data, 64'h0000_0513_8000_0000);
    end
    idu_ready = 1'b1;
    @(negedge clk);
    idu_ready = 1'b0;
    check("drop_valid", {63'd0, ifu_valid}, 64'd0);
    repeat (2) begin
      @(negedge clk);
      check("wait_for_pc", {63'd0, arvalid}, 64'd0);
    end

    // Next PC, then reset while the read is outstanding; a late rvalid must be ignored.
    pc_update_valid = 1'b1; pc_next = 32'h8000_0100;
    @(negedge clk);
    pc_update_valid = 1'b0;
    check("upd_arvalid", {63'd0, arvalid}, 64'd1);
    check("upd_araddr", {32'd0, araddr}, 64'h8000_0100);
    @(negedge clk);
    check("in_s_r", {63'd0, rready}, 64'd1);
    arready = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; rvalid = 1'b1; rdata = 32'hdead_beef;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("late_r_no_valid", {63'd0, ifu_valid}, 64'd0);
      check("late_r_no_rready", {63'd0, rready}, 64'd0);
      check("refetch_addr", {31'd0, arvalid, araddr}, {31'd0, 1'b1, RST_PC});
    end

    // Randomized traffic against a transaction-level model.
    rst = 1'b1; idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    latest_pc = RST_PC; have_new = 1; busy = 0; exp_fault = 0; outstanding = 0;
    stalled = 0; idle = 0; n_fetch = 0; exp_wait = 0; cur_addr = '0; exp_inst = '0;
    prev_arvalid = 0; prev_ifu_valid = 0; prev_idu_ready = 0; prev_araddr = '0; prev_ifu_data = '0;
    for (int c = 0; c < 3000 && !stalled; c++) begin
      @(negedge clk);
      if (arvalid && !prev_arvalid) begin
        check("ar_addr", {32'd0, araddr}, {32'd0, latest_pc});
        check("ar_has_pc", {63'd0, have_new && !busy}, 64'd1);
        have_new = 0; busy = 1; cur_addr = latest_pc;
      end else if (arvalid) begin
        check("ar_stable", {32'd0, araddr}, {32'd0, prev_araddr});
      end
      if (ifu_valid && prev_ifu_valid && !prev_idu_ready)
        check("data_stable", ifu_data, prev_ifu_data);

      arready = ($urandom_range(2) == 0);
      idu_ready = ($urandom_range(2) != 0);
      pc_update_valid = ($urandom_range(5) == 0);
      pc_next = $urandom;
      if (outstanding && r_delay == 0) begin
        rvalid = 1'b1; rdata = mem_word(r_addr); rresp = r_err ? 2'b10 : 2'b00;
      end else begin
        rvalid = 1'b0; rdata = $urandom; rresp = 2'($urandom);
      end
      if ((arvalid && !arready) || (rready && !rvalid)) exp_wait++;

      if (arvalid && arready) begin
        outstanding = 1; r_delay = $urandom_range(3); r_err = ($urandom_range(7) == 0); r_addr = araddr;
      end else if (rvalid && rready) begin
        outstanding = 0;
        exp_inst = r_err ? EBREAK : mem_word(r_addr);
        if (r_err) exp_fault = 1;
      end else if (outstanding && r_delay > 0) begin
        r_delay--;
      end
      if (ifu_valid && idu_ready) begin
        check("out_data", ifu_data, {exp_inst, cur_addr});
        check("out_fault", {63'd0, fetch_fault}, {63'd0, exp_fault});
        busy = 0; n_fetch++; idle = 0;
      end else if (++idle > 80) begin
        check("progress", 64'd0, 64'd1);
        stalled = 1;
      end
      if (pc_update_valid) begin
        latest_pc = pc_next; have_new = 1;
      end
      prev_arvalid = arvalid; prev_araddr = araddr;
      prev_ifu_valid = ifu_valid; prev_ifu_data = ifu_data; prev_idu_ready = idu_ready;
    end
    check("fetch_count_ok", {63'd0, n_fetch >= 100}, 64'd1);
`ifdef IFU_PERF_CNT_EN
    idle_inputs();
    @(negedge clk);
    check("perf_fetch", perf_fetch_cnt, 64'(n_fetch));
    check("perf_wait", perf_wait_cnt, exp_wait);
`endif
    rst = 1'b1; idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    check("fault_cleared", {63'd0, fetch_fault}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch stage of the multi-cycle NPC; sits directly upstream of the decode stage.
- Holds the current PC and issues one 32-bit read per instruction on an AXI4-Lite-style read channel (AR/R).
- Presents {inst, pc} to decode through a valid/ready handshake.
- Waits for the write-back stage to deliver the next PC before starting the next fetch.

Parameters:
- RESET_PC, 32'h8000_0000, PC fetched first after reset.
- ADDR_W, 32, PC/address width (only 32 is supported).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- pc_update_valid  input  1  one-cycle pulse: next PC is available
- pc_next  input  32  next PC; sampled when pc_update_valid=1
- araddr  output  32  fetch address
- arvalid  output  1  read address valid
- arready  input  1  memory accepts address
- rdata  input  32  instruction word
- rresp  input  2  read response, 2'b00 = OKAY
- rvalid  input  1  read data valid
- rready  output  1  stage accepts read data
- ifu_valid  output  1  {inst,pc} valid to decode
- ifu_data  output  64  [63:32] inst, [31:0] pc
- idu_ready  input  1  decode accepts ifu_data
- fetch_fault  output  1  sticky: a non-OKAY rresp was seen

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high, sampled at posedge clk.
- Reset values: state=S_AR, pc=RESET_PC, arvalid=0, rready=0, ifu_valid=0, ifu_data=0, fetch_fault=0, pending=0.
- State machine, 4 states:
  - S_AR: arvalid=1, araddr=pc. On arvalid&arready -> S_R.
  - S_R: rready=1. On rvalid -> latch ifu_data={rdata_or_sub, pc}, go to S_OUT.
  - S_OUT: ifu_valid=1, ifu_data held stable. On idu_ready -> S_WAIT_PC.
  - S_WAIT_PC: all outputs idle.
    - If pending=1, or pc_update_valid=1 this cycle: pc <- selected PC, pending <- 0, go to S_AR.
- arvalid, rready and ifu_valid are registered outputs decoded from state; no combinational path from ready inputs.
- Handshake rules:
  - araddr must not change while arvalid=1.
  - ifu_data must not change while ifu_valid=1 and idu_ready=0.
- Latency: first arvalid in the cycle after rst deasserts.
  - Zero-wait memory (arready=1, and rvalid=1 the cycle after AR): AR cycle, R cycle, ifu_valid on the 3rd cycle.
- pc_update_valid is accepted in every state and never dropped.
  - Outside S_WAIT_PC it loads pc_pending and sets pending=1.
  - A second pulse before consumption overwrites pc_pending (last wins).
- Simultaneous events:
  - pc_update_valid in the same cycle as the S_OUT handshake: it is captured in pending; S_WAIT_PC then lasts exactly one cycle.
  - pc_update_valid in S_WAIT_PC with pending=1: the pulse value wins.
- Response error (rresp!=0):
  - inst is replaced with EBREAK 32'h0010_0073 so the simulator halts.
  - fetch_fault is set; it is cleared only by rst.
- Reset mid-operation (any state, including an outstanding AR/R): return to reset values next cycle. Any late rvalid is ignored until the new S_R.
- pc[1:0]!=0 is fetched as-is; alignment is checked elsewhere.

Optional Feature:
- Macro: IFU_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_fetch_cnt[63:0] (increments on each S_OUT handshake) and perf_wait_cnt[63:0] (increments on each cycle in S_AR with arready=0 or in S_R with rvalid=0).
  - Both counters reset to 0 and wrap modulo 2^64.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package npc_ifu_pkg holds:
  - ifu_state_t enum {S_AR, S_R, S_OUT, S_WAIT_PC}
  - INST_EBREAK = 32'h0010_0073
  - RESP_OKAY = 2'b00
  - default RESET_PC
- Sub-module ifu_perf_cnt holds both counters; it is instantiated only under IFU_PERF_CNT_EN.
- The FSM and datapath stay in ifu_fetch.

Test Plan:
1. Reset then zero-wait memory returning 32'h0000_0513 -> arvalid=1 with araddr=32'h8000_0000 at cycle 1, ifu_valid at cycle 3, ifu_data=64'h0000_0513_8000_0000.
2. idu_ready held 0 for 5 cycles in S_OUT -> ifu_valid stays 1 and ifu_data stays constant; 1 cycle after idu_ready=1, ifu_valid=0.
3. arready delayed 4 cycles and rvalid delayed 3 cycles -> araddr stable throughout; one fetch only; with IFU_PERF_CNT_EN, perf_wait_cnt=7.
4. pc_update_valid with pc_next=32'h8000_0040 during S_R, then a second pulse with 32'h8000_0080 during S_OUT -> next araddr=32'h8000_0080.
5. rresp=2'b10 with rdata=32'h1234_5678 -> ifu_data[63:32]=32'h0010_0073 and fetch_fault=1 until rst.
6. rst asserted while in S_R, then rvalid=1 arrives in the next cycle -> no ifu_valid; fresh fetch from 32'h8000_0000.
